// File: rtl/excpt_handler_pkg.sv
// Shared types and constants for the exception sequencer.
// Cause codes double as the exception-mux vector select.
package excpt_handler_pkg;

    localparam logic [1:0] CAUSE_OPCODE = 2'b00;
    localparam logic [1:0] CAUSE_OVF    = 2'b01;
    localparam logic [1:0] CAUSE_DIV0   = 2'b10;

    localparam logic [7:0] VEC_OPCODE = 8'd253;
    localparam logic [7:0] VEC_OVF    = 8'd254;
    localparam logic [7:0] VEC_DIV0   = 8'd255;

    // Wide enough for MEM_LAT-1 with MEM_LAT up to 4
    localparam int CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SAVE = 2'd1,
        WAIT = 2'd2,
        LOAD = 2'd3
    } state_t;

endpackage

// File: rtl/excpt_handler_priority.sv
// Fixed-priority encoder for exception events.
// Div0 beats Overflow, which beats OpcodeInvalid.
module excpt_priority
    import excpt_handler_pkg::*;
(
    input  logic       i_div0,
    input  logic       i_ovf,
    input  logic       i_opcode,
    output logic       o_valid,
    output logic [1:0] o_cause
);

    always_comb begin
        o_valid = 1'b1;
        o_cause = CAUSE_OPCODE;
        priority case (1'b1)
            i_div0:   o_cause = CAUSE_DIV0;
            i_ovf:    o_cause = CAUSE_OVF;
            i_opcode: o_cause = CAUSE_OPCODE;
            default:  o_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/excpt_handler.sv
// Exception sequencer: SAVE -> WAIT (MEM_LAT-1) -> LOAD.
// Define EXCPT_CAUSE_REG_EN to add the Cause_out register.
module excpt_handler
    import excpt_handler_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        OpcodeInvalid,
    input  logic        Overflow,
    input  logic        Div0,
    input  logic [31:0] PC_in,
    input  logic [31:0] MemData_in,
    output logic [1:0]  ExcptCtrl,
    output logic        MemAddrSel,
    output logic        MemRead,
    output logic        EPCWrite,
    output logic [31:0] EPC_out,
    output logic        PCWrite,
    output logic [31:0] PC_out,
    output logic        Busy
`ifdef EXCPT_CAUSE_REG_EN
    ,
    output logic [31:0] Cause_out
`endif
);

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_cause;
    logic [1:0]       w_cause_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    logic             w_valid;
    logic [1:0]       w_pcause;
    logic             w_unused;

    // Only the low byte of the handler word is used as the new PC
    assign w_unused = &{1'b0, MemData_in[31:8]};

    excpt_priority u_prio (
        .i_div0   (Div0),
        .i_ovf    (Overflow),
        .i_opcode (OpcodeInvalid),
        .o_valid  (w_valid),
        .o_cause  (w_pcause)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cause <= CAUSE_OPCODE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cause <= w_cause_d;
            r_cnt   <= w_cnt_d;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cause_d  = r_cause;
        w_cnt_d    = r_cnt;
        MemAddrSel = 1'b0;
        MemRead    = 1'b0;
        EPCWrite   = 1'b0;
        EPC_out    = '0;
        PCWrite    = 1'b0;
        PC_out     = '0;
        unique case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_next    = SAVE;
                    w_cause_d = w_pcause;
                end
            end
            SAVE: begin
                EPCWrite   = 1'b1;
                EPC_out    = PC_in - 32'd4;
                MemAddrSel = 1'b1;
                MemRead    = 1'b1;
                if (MEM_LAT > 1) begin
                    w_next  = WAIT;
                    w_cnt_d = CNT_W'(MEM_LAT - 1);
                end else begin
                    w_next = LOAD;
                end
            end
            WAIT: begin
                MemAddrSel = 1'b1;
                if (r_cnt <= CNT_W'(1)) begin
                    w_next  = LOAD;
                    w_cnt_d = '0;
                end else begin
                    w_cnt_d = r_cnt - CNT_W'(1);
                end
            end
            LOAD: begin
                PCWrite = 1'b1;
                PC_out  = {24'b0, MemData_in[7:0]};
                w_next  = IDLE;
            end
        endcase
    end

    assign Busy      = (r_state != IDLE);
    assign ExcptCtrl = Busy ? r_cause : CAUSE_OPCODE;

`ifdef EXCPT_CAUSE_REG_EN
    logic [31:0] r_cause_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cause_out <= '0;
        end else if (r_state == SAVE) begin
            r_cause_out <= {30'b0, r_cause};
        end
    end

    assign Cause_out = r_cause_out;
`endif

endmodule

// File: doc/excpt_handler.md
# excpt_handler

Exception sequencer for the multicycle CPU. Detects invalid-opcode, ALU overflow and divide-by-zero events, prioritises them, saves the faulting PC into EPC, drives the exception-vector select code into the downstream exception-address mux, reads the handler byte from memory, and loads it into PC. While a sequence is active it stalls the main control unit.

## Interface
- MEM_LAT, 1: memory read latency in cycles, from the MemRead cycle to MemData_in being valid (1..4).
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- OpcodeInvalid  in  1  main control flags an undefined opcode; single-cycle pulse.
- Overflow  in  1  qualified ALU overflow; single-cycle pulse.
- Div0  in  1  divider divide-by-zero; single-cycle pulse.
- PC_in  in  32  current PC value, already incremented by 4.
- MemData_in  in  32  memory read data.
- ExcptCtrl  out  2  vector select to the exception mux: 00 = 253 (opcode), 01 = 254 (overflow), 10 = 255 (div0).
- MemAddrSel  out  1  routes the exception mux output onto the memory address.
- MemRead  out  1  memory read strobe.
- EPCWrite  out  1  EPC register write enable.
- EPC_out  out  32  EPC write data, equal to PC_in − 4.
- PCWrite  out  1  PC write enable.
- PC_out  out  32  new PC value: {24'b0, MemData_in[7:0]}.
- Busy  out  1  stalls main control while the sequence runs.

## Operation
- FSM states: IDLE, SAVE, WAIT, LOAD.
- IDLE: events are sampled on each rising edge. If any event is high, the cause is latched into a 2-bit register and the FSM goes to SAVE.
- Priority on simultaneous events: Div0 > Overflow > OpcodeInvalid. Lower-priority events in the same cycle are dropped.
- SAVE (1 cycle):
  - EPCWrite=1, EPC_out=PC_in−4 (mod 2^32; PC_in=0 gives 0xFFFFFFFC).
  - MemAddrSel=1, MemRead=1.
- WAIT (MEM_LAT−1 cycles; skipped when MEM_LAT=1): MemAddrSel=1, MemRead=0. A down-counter tracks the remaining cycles.
- LOAD (1 cycle): PCWrite=1, PC_out={24'b0, MemData_in[7:0]}, then return to IDLE.
- ExcptCtrl is driven from the latched cause and held constant from SAVE through LOAD. In IDLE it is 00.
- Busy=1 in SAVE, WAIT and LOAD; 0 in IDLE.
- Events arriving while Busy=1 are ignored and not queued.
- All strobes are 0 in IDLE.
- Reset, from any state including mid-sequence: FSM goes to IDLE, cause=00, counter=0. All outputs are 0: ExcptCtrl=00, strobes 0, EPC_out and PC_out 0, Busy 0.

## Timing
- An event sampled at edge t enters SAVE for cycle t+1.
- LOAD occurs in cycle t+1+MEM_LAT. PCWrite therefore occurs MEM_LAT+1 cycles after the event edge.
- Busy rises in cycle t+1 and falls after LOAD.
- Back-to-back events: a new event is accepted at the first edge in IDLE after LOAD.
- Outputs are Moore-decoded from state, the cause register and PC_in/MemData_in. EPC_out and PC_out are combinational from their inputs, and are valid only while their write strobe is high.

## Configuration
- EXCPT_CAUSE_REG_EN:
  - Defined: adds a 32-bit output Cause_out, a register that is written in SAVE with {30'b0, cause}. It holds until the next exception or reset (reset value 0).
  - Undefined: no Cause_out port and no register. All other behaviour is identical.

## Structure
- Shared package holds:
  - cause encodings CAUSE_OPCODE=2'b00, CAUSE_OVF=2'b01, CAUSE_DIV0=2'b10;
  - state encoding IDLE/SAVE/WAIT/LOAD;
  - vector constants 253/254/255 for use by testbenches.
- One sub-module, excpt_priority: combinational 3-input priority encoder producing a valid flag and a 2-bit cause.

## Test plan
- MEM_LAT=1, Overflow pulse, PC_in=0x00000044, MemData_in=0x000000A7:
  - next cycle EPCWrite=1, EPC_out=0x40, ExcptCtrl=01, MemRead=1;
  - following cycle PCWrite=1, PC_out=0xA7, then Busy=0.
- Div0, Overflow and OpcodeInvalid in the same cycle -> ExcptCtrl=10 for the whole sequence; no second sequence follows.
- MEM_LAT=3, OpcodeInvalid, MemData_in=0xFFFFFF12 -> SAVE, 2 WAIT cycles, then LOAD with PC_out=0x12; Busy high for exactly 4 cycles.
- Overflow pulse while in WAIT -> ignored; FSM returns to IDLE after LOAD with no extra EPCWrite.
- reset asserted during WAIT -> next cycle all outputs 0 and FSM in IDLE; a later Div0 runs a complete, correct sequence.
- PC_in=0x00000000 with an event -> EPC_out=0xFFFFFFFC. With EXCPT_CAUSE_REG_EN defined, Cause_out=0x00000000 for an opcode event and 0x00000002 after a Div0 event.
